// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 codes, access sizes,
// FSM states and small decode helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        AS_BYTE = 2'd0,
        AS_HALF = 2'd1,
        AS_WORD = 2'd2
    } access_size_e;

    typedef enum logic {
        IDLE = 1'b0,
        SEQ  = 1'b1
    } lsu_state_e;

    // Byte count of a load funct3; 0 marks an encoding with no legal load.
    function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: size_bytes = 3'd1;
            F3_H, F3_HU: size_bytes = 3'd2;
            F3_W:        size_bytes = 3'd4;
            default:     size_bytes = 3'd0;
        endcase
    endfunction

    function automatic logic funct3_legal(input logic store, input logic [2:0] funct3);
        if (store) funct3_legal = (funct3 <= F3_W);
        else       funct3_legal = (size_bytes(funct3) != 3'd0);
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Sign/zero extension of raw load data to XLEN; used by both the single-access
// and the byte-assembled load paths.
module lsu_load_ext
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] raw,
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    output logic [XLEN-1:0] data
);

    always_comb begin
        data = raw;
        case (size)
            AS_BYTE: data = is_unsigned ? {{(XLEN-8){1'b0}}, raw[7:0]}
                                        : {{(XLEN-8){raw[7]}}, raw[7:0]};
            AS_HALF: data = is_unsigned ? {{(XLEN-16){1'b0}}, raw[15:0]}
                                        : {{(XLEN-16){raw[15]}}, raw[15:0]};
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// MEM-stage load/store initiator: one access for aligned requests, a byte-by-byte
// sequence for misaligned ones, and one response pulse per accepted request.
module dmem_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [XLEN-1:0]   resp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read_write,
    output logic [1:0]        mem_access_size,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata
);

    lsu_state_e        state, next_state;
    logic [1:0]        byte_idx;
    logic [ADDR_W-1:0] cap_addr;
    logic [2:0]        cap_size;
    logic              cap_unsigned;
    logic              cap_store;
    logic [XLEN-1:0]   cap_wdata;
    logic [XLEN-1:0]   asm_data;
    logic              done;

    logic [2:0]        req_size;
    logic              req_legal;
    logic              req_misaligned;
    logic              seq_last;
    logic              port_write;
    logic [XLEN-1:0]   asm_merged;
    logic [XLEN-1:0]   ext_raw;
    logic [1:0]        ext_size;
    logic              ext_unsigned;
    logic [XLEN-1:0]   ext_data;

    assign req_ready  = (state == IDLE);
    assign resp_valid = done;

    assign req_size       = size_bytes(req_funct3);
    assign req_legal      = funct3_legal(req_store, req_funct3);
    assign req_misaligned = ((req_size == 3'd2) && req_addr[0])
                          || ((req_size == 3'd4) && (req_addr[1:0] != 2'b00));
    assign seq_last       = ({1'b0, byte_idx} == (cap_size - 3'd1));

    // A write enable raised from req_* must never reach memory while reset is held.
    assign mem_read_write = port_write & rst_n;

    lsu_load_ext #(.XLEN(XLEN)) u_ext (
        .raw         (ext_raw),
        .size        (ext_size),
        .is_unsigned (ext_unsigned),
        .data        (ext_data)
    );

    // NOTE: every output of this block is given a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        next_state      = state;
        mem_addr        = '0;
        port_write      = 1'b0;
        mem_access_size = AS_WORD;
        mem_wdata       = '0;
        asm_merged      = asm_data;
        ext_raw         = mem_rdata;
        ext_size        = req_funct3[1:0];
        ext_unsigned    = req_funct3[2];

        case (state)
            IDLE: begin
                if (req_valid && req_legal) begin
                    mem_addr   = req_addr;
                    port_write = req_store;
                    if (!req_misaligned) begin
                        mem_access_size = req_funct3[1:0];
                        mem_wdata       = req_store ? req_wdata : '0;
                    end else begin
                        mem_access_size = AS_BYTE;
                        mem_wdata       = req_store ? {{(XLEN-8){1'b0}}, req_wdata[7:0]} : '0;
                        next_state      = SEQ;
                    end
                end
            end
            SEQ: begin
                mem_addr        = cap_addr + ADDR_W'(byte_idx);
                port_write      = cap_store;
                mem_access_size = AS_BYTE;
                mem_wdata       = cap_store ? {{(XLEN-8){1'b0}}, cap_wdata[8*byte_idx +: 8]} : '0;
                // Current byte is merged in so the last read feeds the extender directly.
                asm_merged[8*byte_idx +: 8] = mem_rdata[7:0];
                ext_raw      = asm_merged;
                ext_size     = (cap_size == 3'd2) ? AS_HALF : AS_WORD;
                ext_unsigned = cap_unsigned;
                if (seq_last) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: state-holding registers use non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx     <= 2'd0;
            cap_addr     <= '0;
            cap_size     <= 3'd0;
            cap_unsigned <= 1'b0;
            cap_store    <= 1'b0;
            cap_wdata    <= '0;
            asm_data     <= '0;
            done         <= 1'b0;
            resp_err     <= 1'b0;
            resp_rdata   <= '0;
        end else begin
            done       <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (!req_legal) begin
                            done     <= 1'b1;
                            resp_err <= 1'b1;
                        end else if (!req_misaligned) begin
                            done       <= 1'b1;
                            resp_rdata <= req_store ? '0 : ext_data;
                        end else begin
                            byte_idx     <= 2'd1;
                            cap_addr     <= req_addr;
                            cap_size     <= req_size;
                            cap_unsigned <= req_funct3[2];
                            cap_store    <= req_store;
                            cap_wdata    <= req_wdata;
                            asm_data     <= {{(XLEN-8){1'b0}}, mem_rdata[7:0]};
                        end
                    end
                end
                SEQ: begin
                    asm_data <= asm_merged;
                    if (seq_last) begin
                        byte_idx   <= 2'd0;
                        done       <= 1'b1;
                        resp_rdata <= cap_store ? '0 : ext_data;
                    end else begin
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
                default: byte_idx <= 2'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: a byte-addressed memory on the port, and a
// reference model computing responses and memory contents from the load/store rules.
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr;
    logic        mem_read_write;
    logic [1:0]  mem_access_size;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;

    always #5 clk = ~clk;

    dmem_lsu #(.ADDR_W(32), .XLEN(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_store       (req_store),
        .req_funct3      (req_funct3),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_err        (resp_err),
        .resp_rdata      (resp_rdata),
        .mem_addr        (mem_addr),
        .mem_read_write  (mem_read_write),
        .mem_access_size (mem_access_size),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata)
    );

    // Memory seen by the DUT, and the model's copy of what it should hold.
    logic [7:0] mem     [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    int n_cmp  = 0;
    int n_bad  = 0;
    int writes = 0;

    function automatic logic [7:0] dflt(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : dflt(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    // Port sampled mid-cycle; a write commits at the following posedge unless in reset.
    logic        pend_w = 1'b0;
    logic [31:0] pend_a, pend_d;
    logic [1:0]  pend_s;

    always @(negedge clk) begin
        pend_w    = mem_read_write;
        pend_a    = mem_addr;
        pend_s    = mem_access_size;
        pend_d    = mem_wdata;
        mem_rdata = {mem_rd(mem_addr + 32'd3), mem_rd(mem_addr + 32'd2),
                     mem_rd(mem_addr + 32'd1), mem_rd(mem_addr)};
    end

    always @(posedge clk) begin
        if (pend_w && rst_n) begin
            for (int j = 0; j < (1 << pend_s); j++) mem[pend_a + 32'(j)] = pend_d[8*j +: 8];
            writes++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] b);
        mem[a]     = b;
        ref_mem[a] = b;
    endtask

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic bit legal_m(input bit st, input logic [2:0] f3);
        return st ? (f3 < 3'd3) : (nbytes(f3) != 0);
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        int          n = nbytes(f3);
        longint      v = 0;
        for (int j = 0; j < n; j++) v += longint'(ref_rd(a + 32'(j))) << (8 * j);
        if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        return v[31:0];
    endfunction

    // One request through the DUT, every observable checked against the model.
    task automatic run_req(input bit st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input string tag, output logic [31:0] rd);
        int          n = nbytes(f3);
        bit          ok = legal_m(st, f3);
        bit          mis = 1'b0;
        int          exp_lat, exp_w, lat, ready_low, w0, g;
        logic [31:0] exp_rd;
        if (ok && n > 1) mis = (a % n) != 0;
        exp_lat = mis ? n : 1;
        exp_w   = (ok && st) ? (mis ? n : 1) : 0;
        exp_rd  = (ok && !st) ? model_load(f3, a) : 32'd0;
        if (ok && st) for (int j = 0; j < n; j++) ref_mem[a + 32'(j)] = wd[8*j +: 8];

        @(posedge clk); #1;
        g = 0;
        while (!req_ready && g < 20) begin @(posedge clk); #1; g++; end
        check({tag, "/ready"}, 32'(req_ready), 32'd1);
        w0 = writes;
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
        lat = 0; ready_low = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (resp_valid) begin lat = c; break; end
            if (!req_ready) ready_low++;
        end
        check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "/err"}, 32'(resp_err), 32'(!ok));
        check({tag, "/rdata"}, resp_rdata, exp_rd);
        check({tag, "/writes"}, 32'(writes - w0), 32'(exp_w));
        check({tag, "/ready_low"}, 32'(ready_low), 32'(exp_lat - 1));
        if (ok && st)
            for (int j = 0; j < n; j++)
                check({tag, "/membyte"}, 32'(mem_rd(a + 32'(j))), 32'(ref_rd(a + 32'(j))));
        rd = resp_rdata;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] exp_q[$];
        int          w0, cnt;

        // Reset values, before any clock edge.
        #2;
        check("rst/resp_valid", 32'(resp_valid), 32'd0);
        check("rst/resp_err", 32'(resp_err), 32'd0);
        check("rst/resp_rdata", resp_rdata, 32'd0);
        check("rst/req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        check("idle/mem_addr", mem_addr, 32'd0);
        check("idle/mem_size", 32'(mem_access_size), 32'd2);
        check("idle/mem_rw", 32'(mem_read_write), 32'd0);
        check("idle/mem_wdata", mem_wdata, 32'd0);

        // 1: aligned word store then load.
        run_req(1'b1, 3'd2, 32'h0100_0000, 32'h8899_AABB, "t1_sw", rd);
        run_req(1'b0, 3'd2, 32'h0100_0000, 32'h0, "t1_lw", rd);
        check("t1/lw_const", rd, 32'h8899_AABB);

        // 2: byte loads of 0x80, signed and unsigned.
        poke(32'h0100_0003, 8'h80);
        run_req(1'b0, 3'd0, 32'h0100_0003, 32'h0, "t2_lb", rd);
        check("t2/lb_const", rd, 32'hFFFF_FF80);
        run_req(1'b0, 3'd4, 32'h0100_0003, 32'h0, "t2_lbu", rd);
        check("t2/lbu_const", rd, 32'h0000_0080);

        // 3: misaligned word store, four byte writes.
        run_req(1'b1, 3'd2, 32'h0100_0001, 32'h1122_3344, "t3_sw", rd);
        check("t3/b1", 32'(mem_rd(32'h0100_0001)), 32'h44);
        check("t3/b2", 32'(mem_rd(32'h0100_0002)), 32'h33);
        check("t3/b3", 32'(mem_rd(32'h0100_0003)), 32'h22);
        check("t3/b4", 32'(mem_rd(32'h0100_0004)), 32'h11);

        // 4: misaligned half loads.
        poke(32'h0100_0005, 8'h34);
        poke(32'h0100_0006, 8'hF2);
        run_req(1'b0, 3'd1, 32'h0100_0005, 32'h0, "t4_lh", rd);
        check("t4/lh_const", rd, 32'hFFFF_F234);
        run_req(1'b0, 3'd5, 32'h0100_0005, 32'h0, "t4_lhu", rd);
        check("t4/lhu_const", rd, 32'h0000_F234);

        // 5: illegal funct3 on a load and a store.
        run_req(1'b0, 3'd3, 32'h0100_0000, 32'h0, "t5_ld3", rd);
        run_req(1'b1, 3'd7, 32'h0100_0000, 32'hFFFF_FFFF, "t5_st7", rd);

        // Address wrap on a misaligned word.
        run_req(1'b1, 3'd2, 32'hFFFF_FFFE, 32'hDEAD_BEEF, "wrap_sw", rd);
        check("wrap/b0", 32'(mem_rd(32'h0000_0000)), 32'hAD);
        check("wrap/b1", 32'(mem_rd(32'h0000_0001)), 32'hDE);
        run_req(1'b0, 3'd2, 32'hFFFF_FFFE, 32'h0, "wrap_lw", rd);
        check("wrap/lw_const", rd, 32'hDEAD_BEEF);

        // Back-to-back aligned requests at one per cycle.
        w0 = writes; cnt = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            bit          st = 1'($urandom);
            logic [2:0]  f3 = (i % 3 == 0) ? 3'd2 : (i % 3 == 1) ? (st ? 3'd1 : 3'd5) : 3'd0;
            int          n = nbytes(f3);
            logic [31:0] a = 32'h0500_0000 + 32'(4 * $urandom_range(0, 1)) + 32'(n * $urandom_range(0, (4 / n) - 1));
            logic [31:0] wd = $urandom;
            exp_q.push_back(st ? 32'd0 : model_load(f3, a));
            if (st) begin
                cnt++;
                for (int j = 0; j < n; j++) ref_mem[a + 32'(j)] = wd[8*j +: 8];
            end
            req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
            @(negedge clk);
            check("b2b/ready", 32'(req_ready), 32'd1);
            if (i > 0) begin
                check("b2b/resp_valid", 32'(resp_valid), 32'd1);
                check("b2b/rdata", resp_rdata, exp_q.pop_front());
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        @(negedge clk);
        check("b2b/last_valid", 32'(resp_valid), 32'd1);
        check("b2b/last_rdata", resp_rdata, exp_q.pop_front());
        check("b2b/writes", 32'(writes - w0), 32'(cnt));
        for (int j = 0; j < 8; j++)
            check("b2b/membyte", 32'(mem_rd(32'h0500_0000 + 32'(j))), 32'(ref_rd(32'h0500_0000 + 32'(j))));

        // 6: reset after byte 1 of a misaligned word store.
        w0 = writes;
        @(posedge clk); #1;
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd2;
        req_addr = 32'h0300_0001; req_wdata = 32'hCAFE_BABE;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("t6/resp_valid_now", 32'(resp_valid), 32'd0);
        check("t6/ready_now", 32'(req_ready), 32'd1);
        check("t6/mem_rw_now", 32'(mem_read_write), 32'd0);
        cnt = 0;
        for (int c = 0; c < 3; c++) begin @(negedge clk); if (resp_valid) cnt++; end
        @(posedge clk); #1; rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin @(negedge clk); if (resp_valid) cnt++; end
        check("t6/no_resp", 32'(cnt), 32'd0);
        check("t6/writes", 32'(writes - w0), 32'd2);
        check("t6/b0", 32'(mem_rd(32'h0300_0001)), 32'hBE);
        check("t6/b1", 32'(mem_rd(32'h0300_0002)), 32'hBA);
        check("t6/b2", 32'(mem_rd(32'h0300_0003)), 32'(dflt(32'h0300_0003)));
        check("t6/b3", 32'(mem_rd(32'h0300_0004)), 32'(dflt(32'h0300_0004)));
        ref_mem[32'h0300_0001] = 8'hBE;
        ref_mem[32'h0300_0002] = 8'hBA;

        // Randomized requests against the model.
        for (int i = 0; i < 60; i++) begin
            bit          st = 1'($urandom);
            logic [2:0]  f3 = 3'($urandom);
            logic [31:0] a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                                         : 32'h0400_0000 + 32'($urandom_range(0, 31));
            run_req(st, f3, a, $urandom, "rand", rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
